// File: rtl/hv_seq_161_sync_if.sv
// Video timing bus between the clock-enable generator and the tilemap/sprite/video-output blocks.
// master drives pixel enable and run/hold; slave (the sequencer) returns counts, blanking and sync.
interface hv_seq_161_sync_if #(
  parameter int HW = 9,
  parameter int VW = 9
);
  logic          Cen;
  logic          Run;
  logic          Hold;
  logic [HW-1:0] H;
  logic [VW-1:0] V;
  logic          HBlank;
  logic          VBlank;
  logic          HSync;
  logic          VSync;
  logic          LineStart;
  logic          FrameStart;
  logic          Field;

  modport master (
    output Cen, Run, Hold,
    input  H, V, HBlank, VBlank, HSync, VSync, LineStart, FrameStart, Field
  );

  modport slave (
    input  Cen, Run, Hold,
    output H, V, HBlank, VBlank, HSync, VSync, LineStart, FrameStart, Field
  );
endinterface

// File: rtl/hv_seq_161_sync.sv
// Preloadable H/V video counters with SR-style blank/sync decode under a run/freeze FSM.
// Optional HVSEQ_FIELD_EN adds a field toggle on every V reload; otherwise Field is tied low.
//
// state    | meaning
// S_IDLE   | stopped, counters and flags hold, waiting for Run
// S_RUN    | counting on each Cen rising edge
// S_FREEZE | Hold high, everything frozen until Hold drops or Run drops
module hv_seq_161_sync #(
  parameter int          HW      = 9,
  parameter int          VW      = 9,
  parameter logic [HW-1:0] H_LOAD  = 9'd128,
  parameter logic [VW-1:0] V_LOAD  = 9'd248,
  parameter logic [HW-1:0] HBL_SET = 9'd448,
  parameter logic [HW-1:0] HBL_CLR = 9'd192,
  parameter logic [HW-1:0] HS_SET  = 9'd464,
  parameter logic [HW-1:0] HS_CLR  = 9'd496,
  parameter logic [VW-1:0] VBL_SET = 9'd496,
  parameter logic [VW-1:0] VBL_CLR = 9'd272,
  parameter logic [VW-1:0] VS_SET  = 9'd504,
  parameter logic [VW-1:0] VS_CLR  = 9'd508
) (
  input  logic                Clk,
  input  logic                Reset,
  hv_seq_161_sync_if.slave    vid
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FREEZE} state_t;

  state_t        state, state_nx;
  logic          last_cen;
  logic          entry_q;
  logic          tick;
  logic          count_en;
  logic [HW-1:0] h_q, h_nx;
  logic [VW-1:0] v_q, v_nx;
  logic          h_wrap, v_wrap;
  logic          hblank_q, hsync_q, vblank_q, vsync_q;
  logic          line_start_q, frame_start_q;

  // Set has priority so a window with SET==CLR stays asserted.
  function automatic logic sr_next_h(input logic cur, input logic [HW-1:0] val,
                                     input logic [HW-1:0] set_v, input logic [HW-1:0] clr_v);
    if (val == set_v)      return 1'b1;
    else if (val == clr_v) return 1'b0;
    else                   return cur;
  endfunction

  function automatic logic sr_next_v(input logic cur, input logic [VW-1:0] val,
                                     input logic [VW-1:0] set_v, input logic [VW-1:0] clr_v);
    if (val == set_v)      return 1'b1;
    else if (val == clr_v) return 1'b0;
    else                   return cur;
  endfunction

  assign tick   = vid.Cen & ~last_cen;
  assign h_wrap = &h_q;
  assign v_wrap = &v_q;
  assign h_nx   = h_wrap ? H_LOAD : h_q + HW'(1);
  assign v_nx   = v_wrap ? V_LOAD : v_q + VW'(1);

  // Run low beats Hold; a tick is dropped on the RUN entry cycle and on any exit from RUN.
  always_comb begin
    state_nx = state;
    count_en = 1'b0;
    unique case (state)
      S_IDLE:   if (vid.Run) state_nx = S_RUN;
      S_RUN:    if (!vid.Run) state_nx = S_IDLE;
                else if (vid.Hold) state_nx = S_FREEZE;
      S_FREEZE: if (!vid.Run) state_nx = S_IDLE;
                else if (!vid.Hold) state_nx = S_RUN;
      default:  state_nx = S_IDLE;
    endcase
    count_en = tick && (state == S_RUN) && (state_nx == S_RUN) && !entry_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= S_IDLE;
      last_cen      <= 1'b1;
      entry_q       <= 1'b0;
      h_q           <= H_LOAD;
      v_q           <= V_LOAD;
      hblank_q      <= 1'b1;
      hsync_q       <= 1'b0;
      vblank_q      <= 1'b1;
      vsync_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state         <= state_nx;
      last_cen      <= vid.Cen;
      entry_q       <= (state != S_RUN) && (state_nx == S_RUN);
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (count_en) begin
        h_q      <= h_nx;
        hblank_q <= sr_next_h(hblank_q, h_nx, HBL_SET, HBL_CLR);
        hsync_q  <= sr_next_h(hsync_q, h_nx, HS_SET, HS_CLR);
        if (h_wrap) begin
          line_start_q  <= 1'b1;
          frame_start_q <= v_wrap;
          v_q           <= v_nx;
          vblank_q      <= sr_next_v(vblank_q, v_nx, VBL_SET, VBL_CLR);
          vsync_q       <= sr_next_v(vsync_q, v_nx, VS_SET, VS_CLR);
        end
      end
    end
  end

`ifdef HVSEQ_FIELD_EN
  logic field_q;

  always_ff @(posedge Clk) begin
    if (Reset)                           field_q <= 1'b0;
    else if (count_en && h_wrap && v_wrap) field_q <= ~field_q;
  end

  assign vid.Field = field_q;
`else
  assign vid.Field = 1'b0;
`endif

  assign vid.H          = h_q;
  assign vid.V          = v_q;
  assign vid.HBlank     = hblank_q;
  assign vid.HSync      = hsync_q;
  assign vid.VBlank     = vblank_q;
  assign vid.VSync      = vsync_q;
  assign vid.LineStart  = line_start_q;
  assign vid.FrameStart = frame_start_q;

endmodule

// File: tb/tb_hv_seq_161_sync.sv
// Scoreboard bench: dut_a uses the default timing, dut_b uses 8-tick lines so a whole frame fits.
// Stimulus pushes expected records per Cen rise or probe; the monitor pops them one Clk later.
module tb_hv_seq_161_sync;

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] v;
    logic [6:0] fl;  // {HBlank, VBlank, HSync, VSync, LineStart, FrameStart, Field}
  } exp_t;

  localparam bit FIELD_ON =
`ifdef HVSEQ_FIELD_EN
    1'b1;
`else
    1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic cen = 1'b1;
  logic run = 1'b0;
  logic hold = 1'b0;

  always #5 Clk = ~Clk;

  hv_seq_161_sync_if #(.HW(9), .VW(9)) bus_a ();
  hv_seq_161_sync_if #(.HW(9), .VW(9)) bus_b ();

  assign bus_a.Cen  = cen;
  assign bus_a.Run  = run;
  assign bus_a.Hold = hold;
  assign bus_b.Cen  = cen;
  assign bus_b.Run  = run;
  assign bus_b.Hold = hold;

  hv_seq_161_sync dut_a (.Clk(Clk), .Reset(Reset), .vid(bus_a));
  hv_seq_161_sync #(.H_LOAD(9'd504)) dut_b (.Clk(Clk), .Reset(Reset), .vid(bus_b));

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   probe_req = 1'b0;
  bit   armed = 1'b0;
  bit   cen_seen = 1'b1;
  int   ls_cnt_a = 0, fs_cnt_a = 0, ls_cnt_b = 0, fs_cnt_b = 0;
  int   exp_ls_a = 0, exp_fs_a = 0, exp_ls_b = 0, exp_fs_b = 0;

  logic [8:0] mh_a, mv_a, mh_b, mv_b;
  logic       fld_a, fld_b;

  // Blank/sync windows written as ranges over the visited count values.
  function automatic exp_t mk(input logic [8:0] h, input logic [8:0] v,
                              input logic ls, input logic fs, input logic fld);
    logic hbl, vbl, hs, vs;
    hbl = (h >= 9'd448) || (h < 9'd192);
    hs  = (h >= 9'd464) && (h < 9'd496);
    vbl = (v >= 9'd496) || (v < 9'd272);
    vs  = (v >= 9'd504) && (v < 9'd508);
    return '{h: h, v: v, fl: {hbl, vbl, hs, vs, ls, fs, fld}};
  endfunction

  task automatic adv(inout logic [8:0] h, inout logic [8:0] v, inout logic fld,
                     input logic [8:0] hl, output logic ls, output logic fs);
    ls = 1'b0;
    fs = 1'b0;
    if (h == 9'd511) begin
      ls = 1'b1;
      h  = hl;
      if (v == 9'd511) begin
        fs  = 1'b1;
        v   = 9'd248;
        fld = fld ^ FIELD_ON;
      end else begin
        v = v + 9'd1;
      end
    end else begin
      h = h + 9'd1;
    end
  endtask

  task automatic model_reset();
    mh_a = 9'd128; mv_a = 9'd248; fld_a = 1'b0;
    mh_b = 9'd504; mv_b = 9'd248; fld_b = 1'b0;
  endtask

  task automatic model_push(input bit cnt);
    logic ls_a, fs_a, ls_b, fs_b;
    ls_a = 1'b0; fs_a = 1'b0; ls_b = 1'b0; fs_b = 1'b0;
    if (cnt) begin
      adv(mh_a, mv_a, fld_a, 9'd128, ls_a, fs_a);
      adv(mh_b, mv_b, fld_b, 9'd504, ls_b, fs_b);
      exp_ls_a += int'(ls_a); exp_fs_a += int'(fs_a);
      exp_ls_b += int'(ls_b); exp_fs_b += int'(fs_b);
    end
    q_a.push_back(mk(mh_a, mv_a, ls_a, fs_a, fld_a));
    q_b.push_back(mk(mh_b, mv_b, ls_b, fs_b, fld_b));
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // One Cen rise, four Clk per tick; cnt says whether the sequencer should count it.
  task automatic tick(input bit cnt);
    cen = 1'b1;
    model_push(cnt);
    clk_wait(2);
    cen = 1'b0;
    clk_wait(2);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  task automatic probe();
    model_push(1'b0);
    probe_req = 1'b1;
    clk_wait(2);
  endtask

  task automatic cmp(input string nm, input exp_t e, input exp_t act);
    n_checks++;
    if (act === e) n_pass++;
    else $display("FAIL %s: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
                  nm, act.h, act.v, act.fl, e.h, e.v, e.fl);
  endtask

  task automatic cmp_int(input string nm, input int act, input int e);
    n_checks++;
    if (act == e) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, e);
  endtask

  function automatic exp_t grab_a();
    return '{h: bus_a.H, v: bus_a.V,
             fl: {bus_a.HBlank, bus_a.VBlank, bus_a.HSync, bus_a.VSync,
                  bus_a.LineStart, bus_a.FrameStart, bus_a.Field}};
  endfunction

  function automatic exp_t grab_b();
    return '{h: bus_b.H, v: bus_b.V,
             fl: {bus_b.HBlank, bus_b.VBlank, bus_b.HSync, bus_b.VSync,
                  bus_b.LineStart, bus_b.FrameStart, bus_b.Field}};
  endfunction

  always @(negedge Clk) begin
    if (armed || probe_req) begin
      if (q_a.size() == 0 || q_b.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_underflow: got empty queue, expected a record");
      end else begin
        cmp("dut_a", q_a.pop_front(), grab_a());
        cmp("dut_b", q_b.pop_front(), grab_b());
      end
    end
    probe_req = 1'b0;
    armed     = cen && !cen_seen;
    cen_seen  = cen;
    if (!Reset) begin
      ls_cnt_a += int'(bus_a.LineStart);
      fs_cnt_a += int'(bus_a.FrameStart);
      ls_cnt_b += int'(bus_b.LineStart);
      fs_cnt_b += int'(bus_b.FrameStart);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    // Reset with Cen held high: the high level after release is not a tick.
    clk_wait(3);
    Reset = 1'b0;
    probe();
    clk_wait(2);
    cen = 1'b0;
    clk_wait(2);

    run = 1'b1;
    clk_wait(3);
    ticks(384);                 // full line: H 511->128, V 248->249
    ticks(122);                 // H=250

    run = 1'b0;
    tick(1'b0);                 // tick coinciding with RUN exit
    for (int i = 0; i < 5; i++) tick(1'b0);
    run = 1'b1;
    clk_wait(1);
    tick(1'b0);                 // tick in the RUN entry cycle
    tick(1'b1);                 // H=251
    ticks(49);                  // H=300

    hold = 1'b1;
    clk_wait(2);
    for (int i = 0; i < 20; i++) tick(1'b0);
    hold = 1'b0;
    clk_wait(2);
    tick(1'b1);                 // H=301
    ticks(99);                  // H=400

    Reset = 1'b1;
    run   = 1'b0;
    clk_wait(1);
    Reset = 1'b0;
    model_reset();
    probe();
    for (int i = 0; i < 3; i++) tick(1'b0);

    run = 1'b1;
    clk_wait(3);
    ticks(2120);                // dut_b wraps a whole 264-line frame

    run = 1'b0;
    clk_wait(4);
    cmp_int("queue_a_drained", q_a.size(), 0);
    cmp_int("queue_b_drained", q_b.size(), 0);
    cmp_int("linestart_cycles_a", ls_cnt_a, exp_ls_a);
    cmp_int("framestart_cycles_a", fs_cnt_a, exp_fs_a);
    cmp_int("linestart_cycles_b", ls_cnt_b, exp_ls_b);
    cmp_int("framestart_cycles_b", fs_cnt_b, exp_fs_b);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
